// File: rtl/sys_ctrl_pkg.sv
// Shared opcodes, operand addresses and FSM state encoding
// for the system command sequencer.
package sys_ctrl_pkg;

   localparam logic [7:0] CMD_RF_WR   = 8'hAA;
   localparam logic [7:0] CMD_RF_RD   = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   localparam int unsigned OPA_ADDR = 0;
   localparam int unsigned OPB_ADDR = 1;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_RD_ADDR,
      ST_RD_WAIT,
      ST_OP_A,
      ST_OP_B,
      ST_ALU_FUNC,
      ST_ALU_WAIT,
      ST_TX_LO,
      ST_TX_HI
   } ctrl_state_e;

endpackage

// File: rtl/sys_ctrl_tx_stage.sv
// TX FIFO push stage: registers one byte per accepted request and
// stalls the requester while the FIFO reports full.
module sys_ctrl_tx_stage #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_full,
   output logic                  o_accept,
   output logic [DATA_WIDTH-1:0] o_tx_data,
   output logic                  o_tx_vld
);

   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_vld;
   logic                  w_accept;

   assign w_accept  = i_push & ~i_full;
   assign o_accept  = w_accept;
   assign o_tx_data = r_data;
   assign o_tx_vld  = r_vld;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_data <= '0;
         r_vld  <= 1'b0;
      end else begin
         r_vld <= w_accept;
         if (w_accept)
            r_data <= i_data;
      end
   end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Byte-serial command sequencer for RF / ALU / TX FIFO.
// Optional inter-byte timeout abort: define CMD_TIMEOUT_EN.
module sys_cmd_ctrl
   import sys_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int FUN_WIDTH      = 4,
   parameter int TIMEOUT_CYCLES = 2048
) (
   input  logic                    REF_CLK,
   input  logic                    RST_N,
   input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
   input  logic                    RX_D_VLD,
   input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
   input  logic                    RF_RD_DATA_VLD,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    ALU_OUT_VLD,
   input  logic                    FIFO_FULL,
   output logic [ADDR_WIDTH-1:0]   RF_ADDR,
   output logic                    RF_WR_EN,
   output logic                    RF_RD_EN,
   output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
   output logic [FUN_WIDTH-1:0]    ALU_FUN,
   output logic                    ALU_EN,
   output logic                    CLK_GATE_EN,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_D_VLD,
   output logic                    CMD_ABORT
);

   ctrl_state_e r_state;

   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_wr_en;
   logic                  r_rd_en;
   logic [DATA_WIDTH-1:0] r_wr_data;
   logic [FUN_WIDTH-1:0]  r_fun;
   logic                  r_alu_en;
   logic                  r_gate_en;
   logic                  r_abort;
   logic [DATA_WIDTH-1:0] r_tx_lo;
   logic [DATA_WIDTH-1:0] r_tx_hi;

   logic                  w_push;
   logic [DATA_WIDTH-1:0] w_push_data;
   logic                  w_accept;
   logic                  w_timeout;

   assign RF_ADDR     = r_addr;
   assign RF_WR_EN    = r_wr_en;
   assign RF_RD_EN    = r_rd_en;
   assign RF_WR_DATA  = r_wr_data;
   assign ALU_FUN     = r_fun;
   assign ALU_EN      = r_alu_en;
   assign CLK_GATE_EN = r_gate_en;
   assign CMD_ABORT   = r_abort;

`ifdef CMD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             w_timed;

   assign w_timed = (r_state == ST_WR_ADDR)  ||
                    (r_state == ST_WR_DATA)  ||
                    (r_state == ST_RD_ADDR)  ||
                    (r_state == ST_OP_A)     ||
                    (r_state == ST_OP_B)     ||
                    (r_state == ST_ALU_FUNC);

   assign w_timeout = w_timed && !RX_D_VLD &&
                      (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge REF_CLK) begin
      if (!RST_N)
         r_tmo_cnt <= '0;
      else if (RX_D_VLD || !w_timed || w_timeout)
         r_tmo_cnt <= '0;
      else
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
   end
`else
   assign w_timeout = 1'b0;
`endif

   // Responses are pushed in the same edge that sees the data, so the
   // first byte reaches the FIFO one cycle after its valid pulse.
   always_comb begin
      w_push      = 1'b0;
      w_push_data = '0;
      case (r_state)
         ST_RD_WAIT: begin
            w_push      = RF_RD_DATA_VLD;
            w_push_data = RF_RD_DATA;
         end
         ST_ALU_WAIT: begin
            w_push      = ALU_OUT_VLD;
            w_push_data = ALU_OUT[DATA_WIDTH-1:0];
         end
         ST_TX_LO: begin
            w_push      = 1'b1;
            w_push_data = r_tx_lo;
         end
         ST_TX_HI: begin
            w_push      = 1'b1;
            w_push_data = r_tx_hi;
         end
         default: ;
      endcase
   end

   sys_ctrl_tx_stage #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_tx_stage (
      .i_clk    (REF_CLK),
      .i_rst_n  (RST_N),
      .i_push   (w_push),
      .i_data   (w_push_data),
      .i_full   (FIFO_FULL),
      .o_accept (w_accept),
      .o_tx_data(TX_P_DATA),
      .o_tx_vld (TX_D_VLD)
   );

   always_ff @(posedge REF_CLK) begin
      if (!RST_N) begin
         r_state   <= ST_IDLE;
         r_addr    <= '0;
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
         r_wr_data <= '0;
         r_fun     <= '0;
         r_alu_en  <= 1'b0;
         r_gate_en <= 1'b0;
         r_abort   <= 1'b0;
         r_tx_lo   <= '0;
         r_tx_hi   <= '0;
      end else begin
         r_wr_en <= 1'b0;
         r_rd_en <= 1'b0;
         r_abort <= 1'b0;
         if (w_timeout) begin
            r_state <= ST_IDLE;
            r_abort <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (RX_D_VLD) begin
                     case (RX_P_DATA)
                        DATA_WIDTH'(CMD_RF_WR):   r_state <= ST_WR_ADDR;
                        DATA_WIDTH'(CMD_RF_RD):   r_state <= ST_RD_ADDR;
                        DATA_WIDTH'(CMD_ALU_OP):  r_state <= ST_OP_A;
                        DATA_WIDTH'(CMD_ALU_NOP): r_state <= ST_ALU_FUNC;
                        default: ;
                     endcase
                  end
               end
               ST_WR_ADDR: begin
                  if (RX_D_VLD) begin
                     r_addr  <= RX_P_DATA[ADDR_WIDTH-1:0];
                     r_state <= ST_WR_DATA;
                  end
               end
               ST_WR_DATA: begin
                  if (RX_D_VLD) begin
                     r_wr_en   <= 1'b1;
                     r_wr_data <= RX_P_DATA;
                     r_state   <= ST_IDLE;
                  end
               end
               ST_RD_ADDR: begin
                  if (RX_D_VLD) begin
                     r_addr  <= RX_P_DATA[ADDR_WIDTH-1:0];
                     r_rd_en <= 1'b1;
                     r_state <= ST_RD_WAIT;
                  end
               end
               ST_RD_WAIT: begin
                  if (RF_RD_DATA_VLD) begin
                     r_tx_hi <= RF_RD_DATA;
                     r_state <= w_accept ? ST_IDLE : ST_TX_HI;
                  end
               end
               ST_OP_A: begin
                  if (RX_D_VLD) begin
                     r_addr    <= ADDR_WIDTH'(OPA_ADDR);
                     r_wr_en   <= 1'b1;
                     r_wr_data <= RX_P_DATA;
                     r_state   <= ST_OP_B;
                  end
               end
               ST_OP_B: begin
                  if (RX_D_VLD) begin
                     r_addr    <= ADDR_WIDTH'(OPB_ADDR);
                     r_wr_en   <= 1'b1;
                     r_wr_data <= RX_P_DATA;
                     r_state   <= ST_ALU_FUNC;
                  end
               end
               ST_ALU_FUNC: begin
                  if (RX_D_VLD) begin
                     r_fun     <= RX_P_DATA[FUN_WIDTH-1:0];
                     r_alu_en  <= 1'b1;
                     r_gate_en <= 1'b1;
                     r_state   <= ST_ALU_WAIT;
                  end
               end
               ST_ALU_WAIT: begin
                  if (ALU_OUT_VLD) begin
                     r_alu_en  <= 1'b0;
                     r_gate_en <= 1'b0;
                     r_tx_lo   <= ALU_OUT[DATA_WIDTH-1:0];
                     r_tx_hi   <= ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                     r_state   <= w_accept ? ST_TX_HI : ST_TX_LO;
                  end
               end
               ST_TX_LO: begin
                  if (w_accept)
                     r_state <= ST_TX_HI;
               end
               ST_TX_HI: begin
                  if (w_accept)
                     r_state <= ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed self-checking bench for sys_cmd_ctrl.
// Timeout scenario is exercised when CMD_TIMEOUT_EN is defined.
module tb_sys_cmd_ctrl;

   localparam int TMO = 2048;

   logic        clk = 1'b0;
   logic        RST_N;
   logic [7:0]  RX_P_DATA;
   logic        RX_D_VLD;
   logic [7:0]  RF_RD_DATA;
   logic        RF_RD_DATA_VLD;
   logic [15:0] ALU_OUT;
   logic        ALU_OUT_VLD;
   logic        FIFO_FULL;
   logic [3:0]  RF_ADDR;
   logic        RF_WR_EN;
   logic        RF_RD_EN;
   logic [7:0]  RF_WR_DATA;
   logic [3:0]  ALU_FUN;
   logic        ALU_EN;
   logic        CLK_GATE_EN;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        CMD_ABORT;

   int n_checks = 0;
   int n_errors = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int full_viol = 0;
   int abort_cnt = 0;
   logic [7:0] rf [16];
   logic [7:0] tx_q [$];

   always #5 clk = ~clk;

   sys_cmd_ctrl #(
      .DATA_WIDTH(8), .ADDR_WIDTH(4),
      .FUN_WIDTH(4), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .REF_CLK(clk), .RST_N(RST_N),
      .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
      .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
      .FIFO_FULL(FIFO_FULL), .RF_ADDR(RF_ADDR),
      .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
      .RF_WR_DATA(RF_WR_DATA), .ALU_FUN(ALU_FUN),
      .ALU_EN(ALU_EN), .CLK_GATE_EN(CLK_GATE_EN),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
      .CMD_ABORT(CMD_ABORT)
   );

   always @(posedge clk) begin
      if (RF_WR_EN) begin
         wr_cnt++;
         rf[RF_ADDR] = RF_WR_DATA;
      end
      if (RF_RD_EN) rd_cnt++;
      if (TX_D_VLD) begin
         tx_q.push_back(TX_P_DATA);
         if (FIFO_FULL) full_viol++;
      end
      if (CMD_ABORT) abort_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      tick();
      RX_D_VLD  = 1'b0;
   endtask

   task automatic do_read(input logic [7:0] a, input logic [7:0] exp,
                          input string tag);
      send(8'hBB);
      send(a);
      check({tag, "_rd_en"}, RF_RD_EN, 1);
      check({tag, "_rd_addr"}, RF_ADDR, a[3:0]);
      RF_RD_DATA     = rf[a[3:0]];
      RF_RD_DATA_VLD = 1'b1;
      tick();
      RF_RD_DATA_VLD = 1'b0;
      check({tag, "_tx_vld"}, TX_D_VLD, 1);
      check({tag, "_tx_data"}, TX_P_DATA, exp);
      tick();
      check({tag, "_tx_single"}, TX_D_VLD, 0);
      check({tag, "_tx_count"}, tx_q.size(), 1);
      tx_q.delete();
   endtask

   initial begin
      foreach (rf[i]) rf[i] = 8'h00;
      RST_N = 1'b0;
      RX_P_DATA = '0; RX_D_VLD = 1'b0;
      RF_RD_DATA = '0; RF_RD_DATA_VLD = 1'b0;
      ALU_OUT = '0; ALU_OUT_VLD = 1'b0;
      FIFO_FULL = 1'b0;
      repeat (3) tick();
      check("rst_wr_en", RF_WR_EN, 0);
      check("rst_rd_en", RF_RD_EN, 0);
      check("rst_tx_vld", TX_D_VLD, 0);
      check("rst_alu_en", {ALU_EN, CLK_GATE_EN}, 0);
      check("rst_vectors", {RF_ADDR, RF_WR_DATA, ALU_FUN, TX_P_DATA}, 0);
      check("rst_abort", CMD_ABORT, 0);
      RST_N = 1'b1;
      tick();

      // RF write
      send(8'hAA); send(8'h0A); send(8'h6F);
      check("wr_en", RF_WR_EN, 1);
      check("wr_addr", RF_ADDR, 4'hA);
      check("wr_data", RF_WR_DATA, 8'h6F);
      tick();
      check("wr_pulse", RF_WR_EN, 0);
      tick();
      check("wr_count", wr_cnt, 1);
      check("wr_no_tx", tx_q.size(), 0);

      // RF read of the byte just written
      do_read(8'h0A, 8'h6F, "rd");
      check("rd_count", rd_cnt, 1);

      // ALU with operands
      send(8'hCC); send(8'h40);
      check("opa_wr", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b1, 4'h0, 8'h40});
      send(8'h04);
      check("opb_wr", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b1, 4'h1, 8'h04});
      send(8'h00);
      check("alu_en", {ALU_EN, CLK_GATE_EN, ALU_FUN}, {2'b11, 4'h0});
      tick(); tick();
      check("alu_en_hold", {ALU_EN, CLK_GATE_EN}, 2'b11);
      ALU_OUT = 16'h0044; ALU_OUT_VLD = 1'b1;
      tick();
      ALU_OUT_VLD = 1'b0;
      check("alu_lo", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h44});
      check("alu_en_drop", {ALU_EN, CLK_GATE_EN}, 2'b00);
      tick();
      check("alu_hi", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h00});
      tick();
      check("alu_tx_end", TX_D_VLD, 0);
      check("alu_rf_ops", {rf[0], rf[1]}, 16'h4004);
      check("alu_tx_n", tx_q.size(), 2);
      tx_q.delete();

      // ALU on stored operands with FIFO backpressure
      send(8'hDD); send(8'h02);
      check("nop_fun", {ALU_EN, ALU_FUN}, {1'b1, 4'h2});
      FIFO_FULL = 1'b1;
      ALU_OUT = 16'h0100; ALU_OUT_VLD = 1'b1;
      tick();
      ALU_OUT_VLD = 1'b0;
      check("bp_en_drop", ALU_EN, 0);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_stall%0d", i), TX_D_VLD, 0);
         if (i < 4) tick();
      end
      FIFO_FULL = 1'b0;
      tick();
      check("bp_lo", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h00});
      tick();
      check("bp_hi", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h01});
      tick();
      check("bp_end", TX_D_VLD, 0);
      check("bp_tx_n", tx_q.size(), 2);
      if (tx_q.size() == 2)
         check("bp_order", {tx_q[0], tx_q[1]}, 16'h0001);
      tx_q.delete();
      check("full_viol", full_viol, 0);

      // Illegal opcode, then reset in the middle of a write
      send(8'h55);
      tick();
      check("ill_strobes", {wr_cnt[7:0], rd_cnt[7:0]}, {8'd3, 8'd1});
      send(8'hAA); send(8'h0F);
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
      check("mid_rst_wr", RF_WR_EN, 0);
      send(8'hFF);
      tick();
      check("mid_rst_nowr", wr_cnt, 3);
      do_read(8'h00, 8'h40, "post_rst");

`ifdef CMD_TIMEOUT_EN
      send(8'hAA); send(8'h03);
      for (int i = 0; i < TMO + 20; i++) tick();
      check("tmo_abort", abort_cnt, 1);
      check("tmo_nowr", wr_cnt, 3);
      do_read(8'h03, 8'h00, "tmo_rd");
`else
      send(8'hAA); send(8'h03);
      repeat (50) tick();
      send(8'h77);
      check("late_wr", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b1, 4'h3, 8'h77});
      tick();
      check("no_abort", abort_cnt, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
